dragon_head_controller: RTL

//  Upstream feeder of the dragon body shift register. Steps the dragon head one grid cell toward
//  the player every MOVE_DIV frames and emits one 12-bit {orientation, position} head segment

---
 rtl/dragon_pkg.sv | 32 +++
 rtl/dragon_dir_select.sv | 51 +++++
 rtl/dragon_head_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dragon_pkg.sv
// Shared definitions for the dragon head controller, body store and renderer.
// Covers body command codes, direction codes and the 12-bit head segment layout.
package dragon_pkg;

    localparam int unsigned SEG_W   = 12;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned POS_W   = 8;
    localparam int unsigned LEN_W   = 4;

    typedef enum logic [1:0] {
        CMD_MOVE = 2'b00,
        CMD_HEAL = 2'b01,
        CMD_HIT  = 2'b10,
        CMD_IDLE = 2'b11
    } body_cmd_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    // Field layout of a head segment, MSB first: dir[11:10], reserved[9:8], x[7:4], y[3:0].
    typedef struct packed {
        dir_e                 dir;
        logic [1:0]           rsvd;
        logic [COORD_W-1:0]   x;
        logic [COORD_W-1:0]   y;
    } head_seg_t;

endpackage

// File: rtl/dragon_dir_select.sv
// Combinational step selector: from the current head and the (clamped) target,
// picks the next head cell one step closer and the direction of that step.
module dragon_dir_select
    import dragon_pkg::*;
#(
    parameter int unsigned GRID_W = 16,
    parameter int unsigned GRID_H = 12
) (
    input  logic [COORD_W-1:0] head_x_i,
    input  logic [COORD_W-1:0] head_y_i,
    input  logic [POS_W-1:0]   target_pos_i,
    output logic [COORD_W-1:0] next_x_c_o,
    output logic [COORD_W-1:0] next_y_c_o,
    output dir_e               dir_c_o,
    output logic               at_target_c_o
);

    localparam logic [COORD_W:0] X_MAX = (COORD_W+1)'(GRID_W - 1);
    localparam logic [COORD_W:0] Y_MAX = (COORD_W+1)'(GRID_H - 1);

    logic [COORD_W-1:0] tx_raw, ty_raw, tx, ty;
    logic signed [COORD_W:0] dx, dy;
    logic [COORD_W:0] adx, ady;

    assign tx_raw = target_pos_i[7:4];
    assign ty_raw = target_pos_i[3:0];
    assign tx = ({1'b0, tx_raw} > X_MAX) ? X_MAX[COORD_W-1:0] : tx_raw;
    assign ty = ({1'b0, ty_raw} > Y_MAX) ? Y_MAX[COORD_W-1:0] : ty_raw;

    assign dx  = $signed({1'b0, tx}) - $signed({1'b0, head_x_i});
    assign dy  = $signed({1'b0, ty}) - $signed({1'b0, head_y_i});
    assign adx = dx[COORD_W] ? (COORD_W+1)'(-dx) : (COORD_W+1)'(dx);
    assign ady = dy[COORD_W] ? (COORD_W+1)'(-dy) : (COORD_W+1)'(dy);

    assign at_target_c_o = (dx == '0) && (dy == '0);

    // Horizontal wins ties; y grows downward.
    always_comb begin
        next_x_c_o = head_x_i;
        next_y_c_o = head_y_i;
        dir_c_o    = DIR_RIGHT;
        if ((adx >= ady) && (dx != '0)) begin
            next_x_c_o = dx[COORD_W] ? head_x_i - 4'd1 : head_x_i + 4'd1;
            dir_c_o    = dx[COORD_W] ? DIR_LEFT : DIR_RIGHT;
        end else if (dy != '0) begin
            next_y_c_o = dy[COORD_W] ? head_y_i - 4'd1 : head_y_i + 4'd1;
            dir_c_o    = dy[COORD_W] ? DIR_UP : DIR_DOWN;
        end
    end

endmodule

// File: rtl/dragon_head_controller.sv
// Dragon head controller: steps the head toward the player every MOVE_DIV frames and
// emits one head segment plus body command, keeping body length within 1..MAX_LEN.
module dragon_head_controller
    import dragon_pkg::*;
#(
    parameter int unsigned GRID_W   = 16,
    parameter int unsigned GRID_H   = 12,
    parameter int unsigned MAX_LEN  = 8,
    parameter int unsigned MOVE_DIV = 4,
    parameter int unsigned START_X  = 0,
    parameter int unsigned START_Y  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              enable,
    input  logic [POS_W-1:0]  target_pos,
    input  logic              heal_evt,
    input  logic              hit_evt,
    output logic              seg_valid,
    output logic [1:0]        body_cmd,
    output logic [SEG_W-1:0]  head_segment,
    output logic [LEN_W-1:0]  dragon_len
);

    localparam int unsigned    DIV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {S_WAIT, S_COMPUTE, S_EMIT} state_e;

    state_e             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [COORD_W-1:0] hx_q, hy_q;
    dir_e               dir_q;
    body_cmd_e          cmd_q;
    logic [LEN_W-1:0]   len_q;
    logic               heal_q, hit_q, seg_valid_q;

    logic [COORD_W-1:0] nx_c, ny_c;
    dir_e               ndir_c;
    logic               at_target_c;
    logic               heal_now, hit_now;
    body_cmd_e          cmd_d;
    logic [LEN_W-1:0]   len_d;
    head_seg_t          seg;

    dragon_dir_select #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_dir_select (
        .head_x_i      (hx_q),
        .head_y_i      (hy_q),
        .target_pos_i  (target_pos),
        .next_x_c_o    (nx_c),
        .next_y_c_o    (ny_c),
        .dir_c_o       (ndir_c),
        .at_target_c_o (at_target_c)
    );

    // An event landing in the COMPUTE cycle is folded into this emit rather than lost.
    assign heal_now = heal_q | heal_evt;
    assign hit_now  = hit_q  | hit_evt;

    always_comb begin
        cmd_d = CMD_MOVE;
        len_d = len_q;
        if (heal_now && !hit_now && (len_q < LEN_MAX)) begin
            cmd_d = CMD_HEAL;
            len_d = len_q + 4'd1;
        end else if (hit_now && !heal_now && (len_q > 4'd1)) begin
            cmd_d = CMD_HIT;
            len_d = len_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_WAIT;
            div_q       <= '0;
            hx_q        <= COORD_W'(START_X);
            hy_q        <= COORD_W'(START_Y);
            dir_q       <= DIR_RIGHT;
            cmd_q       <= CMD_IDLE;
            len_q       <= 4'd1;
            heal_q      <= 1'b0;
            hit_q       <= 1'b0;
            seg_valid_q <= 1'b0;
        end else begin
            seg_valid_q <= 1'b0;
            heal_q      <= heal_now;
            hit_q       <= hit_now;
            case (state_q)
                S_WAIT: begin
                    if (frame_tick && enable) begin
                        if (div_q == DIV_LAST) begin
                            div_q   <= '0;
                            state_q <= S_COMPUTE;
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    // Outputs register on leaving COMPUTE so the strobe is seen during EMIT.
                    if (at_target_c) begin
                        state_q <= S_WAIT;
                    end else begin
                        state_q     <= S_EMIT;
                        hx_q        <= nx_c;
                        hy_q        <= ny_c;
                        dir_q       <= ndir_c;
                        cmd_q       <= cmd_d;
                        len_q       <= len_d;
                        heal_q      <= 1'b0;
                        hit_q       <= 1'b0;
                        seg_valid_q <= 1'b1;
                    end
                end
                S_EMIT:  state_q <= S_WAIT;
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign seg          = '{dir: dir_q, rsvd: 2'b00, x: hx_q, y: hy_q};
    assign head_segment = seg;
    assign seg_valid    = seg_valid_q;
    assign body_cmd     = cmd_q;
    assign dragon_len   = len_q;

endmodule
